// File: rtl/fpu_result_ctrl.sv
// Result/stall controller for a multi-cycle FPU: it accepts an op and holds the core
// for the op's latency, then registers the datapath result with a one-cycle valid pulse.
module fpu_result_ctrl #(
   parameter int unsigned DIV_LAT  = 24,
   parameter int unsigned SQRT_LAT = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [4:0]  op,
   input  logic        flush,
   input  logic [31:0] res_in,
   input  logic [4:0]  flags_in,
   output logic        stall,
   output logic        res_valid,
   output logic [31:0] res_out,
   output logic [4:0]  flags_out,
   output logic [4:0]  op_q,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t     state;
   logic [5:0] count;

   // Counter preload is latency minus one, so the final EXEC cycle sees count==0.
   function automatic logic [5:0] lat_m1(input logic [4:0] o);
      logic [5:0] l;
      l = 6'd1;
      casez (o)
         5'b0001?, 5'b01011: l = 6'd2;
         5'b0011?:           l = 6'(DIV_LAT);
         5'b01101:           l = 6'(SQRT_LAT);
         default:            l = 6'd1;
      endcase
      return l - 6'd1;
   endfunction

   // Reset is folded in so a core holding start high during reset sees no stall.
   assign stall = reset && (((state == IDLE) && start && !flush) || (state == EXEC));

   // NOTE: all state here is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         op_q      <= '0;
         res_out   <= '0;
         flags_out <= '0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         count     <= '0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= op;
                  count <= lat_m1(op);
                  busy  <= 1'b1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (count != 6'd0) begin
                  count <= count - 6'd1;
               end else begin
                  res_out   <= res_in;
                  flags_out <= flags_in;
                  res_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_result_ctrl.sv
// Directed bench for fpu_result_ctrl: latency, back-to-back accept, flush and
// mid-operation reset, all against hand-computed cycle numbers.
module tb_fpu_result_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  op;
   logic        flush;
   logic [31:0] res_in;
   logic [4:0]  flags_in;
   logic        stall;
   logic        res_valid;
   logic [31:0] res_out;
   logic [4:0]  flags_out;
   logic [4:0]  op_q;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int busy_cnt;
   int rv_cnt;

   fpu_result_ctrl #(.DIV_LAT(24), .SQRT_LAT(24)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .flush(flush),
      .res_in(res_in), .flags_in(flags_in), .stall(stall), .res_valid(res_valid),
      .res_out(res_out), .flags_out(flags_out), .op_q(op_q), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven from here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; start = 1'b1; op = 5'b00000; flush = 1'b0;
      res_in = '0; flags_in = '0;

      // Reset state, with start held high
      #3;
      check("rst_stall", stall, 0);
      check("rst_valid", res_valid, 0);
      check("rst_res", res_out, 0);
      check("rst_flags", flags_out, 0);
      check("rst_opq", op_q, 0);
      check("rst_busy", busy, 0);
      cyc();
      check("rst_stall_edge", stall, 0);
      check("rst_busy_edge", busy, 0);

      // Release, then single-cycle op accepted on first edge after release
      reset = 1'b1; op = 5'b00000; res_in = 32'h3F80_0000; start = 1'b1;
      #1 check("l1_t0_stall", stall, 1);
      cyc(); #1;
      check("l1_t1_busy", busy, 1);
      check("l1_t1_stall", stall, 1);
      check("l1_t1_valid", res_valid, 0);
      cyc(); start = 1'b0; #1;
      check("l1_t2_valid", res_valid, 1);
      check("l1_t2_res", res_out, 32'h3F80_0000);
      check("l1_t2_stall", stall, 0);
      check("l1_t2_busy", busy, 0);
      cyc(); #1;
      check("l1_t3_valid", res_valid, 0);

      // Two-cycle op with start held through DONE
      cyc(); op = 5'b00010; start = 1'b1; res_in = 32'h1234_5678; flags_in = 5'b00100; #1;
      check("l2_t0_stall", stall, 1);
      cyc(); #1;
      check("l2_t1_busy", busy, 1);
      check("l2_t1_opq", op_q, 5'b00010);
      cyc(); #1;
      check("l2_t2_stall", stall, 1);
      check("l2_t2_valid", res_valid, 0);
      cyc(); #1;
      check("l2_t3_valid", res_valid, 1);
      check("l2_t3_stall", stall, 0);
      check("l2_t3_res", res_out, 32'h1234_5678);
      check("l2_t3_flags", flags_out, 5'b00100);
      cyc(); res_in = 32'h0000_0002; #1;
      check("l2_t4_stall", stall, 1);
      check("l2_t4_valid", res_valid, 0);
      check("l2_t4_busy", busy, 0);
      cyc(); start = 1'b0; #1;
      check("l2_t5_busy", busy, 1);
      cyc(); #1;
      check("l2_t6_busy", busy, 1);
      cyc(); #1;
      check("l2_t7_valid", res_valid, 1);
      check("l2_t7_res", res_out, 32'h0000_0002);

      // Op 01011 is also two cycles, accepted in the cycle right after DONE
      cyc(); op = 5'b01011; start = 1'b1; res_in = 32'h0000_0055; #1;
      check("l2b_t0_stall", stall, 1);
      cyc(); start = 1'b0; #1;
      cyc(); #1;
      check("l2b_t2_busy", busy, 1);
      check("l2b_t2_valid", res_valid, 0);
      cyc(); #1;
      check("l2b_t3_valid", res_valid, 1);
      check("l2b_t3_res", res_out, 32'h0000_0055);

      // Divide: op and start change mid-EXEC, 24 busy cycles, valid at T25
      cyc(); op = 5'b00110; start = 1'b1; res_in = 32'hCAFE_BABE; flags_in = 5'b00001; #1;
      check("div_t0_stall", stall, 1);
      busy_cnt = 0; rv_cnt = 0;
      for (int i = 1; i <= 24; i++) begin
         cyc();
         if (i == 1) begin
            start = 1'b0;
            op    = 5'b00000;
         end
         #1;
         busy_cnt += int'(busy);
         rv_cnt   += int'(res_valid);
         if (i == 12) begin
            check("div_mid_opq", op_q, 5'b00110);
            check("div_mid_res", res_out, 32'h0000_0055);
            check("div_mid_stall", stall, 1);
         end
         if (i == 24) check("div_t24_stall", stall, 1);
      end
      check("div_busy_cycles", busy_cnt, 24);
      check("div_early_valid", rv_cnt, 0);
      cyc(); #1;
      check("div_t25_valid", res_valid, 1);
      check("div_t25_res", res_out, 32'hCAFE_BABE);
      check("div_t25_flags", flags_out, 5'b00001);
      check("div_t25_opq", op_q, 5'b00110);
      check("div_t25_busy", busy, 0);

      // Sqrt flushed at T5
      cyc(); op = 5'b01101; start = 1'b1; res_in = 32'hDEAD_BEEF; flags_in = 5'b10000; #1;
      check("sq_t0_stall", stall, 1);
      cyc(); start = 1'b0;
      cyc(); cyc(); cyc();
      cyc(); flush = 1'b1; #1;
      check("sq_t5_stall", stall, 1);
      cyc(); flush = 1'b0; #1;
      check("sq_t6_busy", busy, 0);
      check("sq_t6_stall", stall, 0);
      check("sq_t6_valid", res_valid, 0);
      rv_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(); #1;
         rv_cnt += int'(res_valid);
      end
      check("sq_no_valid", rv_cnt, 0);
      check("sq_res_kept", res_out, 32'hCAFE_BABE);
      check("sq_flags_kept", flags_out, 5'b00001);
      check("sq_opq_kept", op_q, 5'b01101);

      // Flush beats start in IDLE
      cyc(); op = 5'b00000; start = 1'b1; flush = 1'b1; #1;
      check("fl_idle_stall", stall, 0);
      cyc(); start = 1'b0; flush = 1'b0; #1;
      check("fl_idle_busy", busy, 0);

      // Divide interrupted by reset at T10
      cyc(); op = 5'b00110; start = 1'b1; res_in = 32'h1111_1111; #1;
      for (int i = 1; i <= 9; i++) begin
         cyc();
         if (i == 1) start = 1'b0;
      end
      cyc(); #1;
      check("rst_mid_busy_pre", busy, 1);
      reset = 1'b0; start = 1'b1; #1;
      check("rst_mid_res", res_out, 0);
      check("rst_mid_flags", flags_out, 0);
      check("rst_mid_opq", op_q, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_stall", stall, 0);
      check("rst_mid_valid", res_valid, 0);
      cyc(); start = 1'b0; reset = 1'b1;
      rv_cnt = 0; busy_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(); #1;
         rv_cnt   += int'(res_valid);
         busy_cnt += int'(busy);
      end
      check("rst_after_valid", rv_cnt, 0);
      check("rst_after_busy", busy_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fpu_result_ctrl.md
FPU_RESULT_CTRL -- requirements
Module: fpu_result_ctrl

Interface
REQ-001 Parameter DIV_LAT, default 24: execute cycles for divide ops, legal range 1..63.
REQ-002 Parameter SQRT_LAT, default 24: execute cycles for square-root op, legal range 1..63.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  core level request; held high by core until stall is seen low.
REQ-006 op  input  5  FPU operation code, valid while start high.
REQ-007 flush  input  1  synchronous pipeline flush; aborts any operation in progress.
REQ-008 res_in  input  32  arithmetic datapath result.
REQ-009 flags_in  input  5  datapath exception flags (NV,DZ,OF,UF,NX).
REQ-010 stall  output  1  core must hold the pipeline while high.
REQ-011 res_valid  output  1  one-cycle pulse; res_out/flags_out hold a new result.
REQ-012 res_out  output  32  registered result.
REQ-013 flags_out  output  5  registered exception flags.
REQ-014 op_q  output  5  op latched at accept, driven to datapath for the whole operation.
REQ-015 busy  output  1  high in EXEC state.

Function
REQ-016 States SHALL be IDLE, EXEC, DONE; encoding free.
REQ-017 Latency L per op: 5'b0001? and 5'b01011 -> 2; 5'b0011? -> DIV_LAT; 5'b01101 -> SQRT_LAT; all others -> 1.
REQ-018 IDLE: start=1 and flush=0 -> latch op into op_q, load 6-bit counter with L-1, go EXEC; else stay IDLE.
REQ-019 EXEC: counter!=0 -> decrement, stay EXEC; counter==0 -> capture res_in/flags_in into res_out/flags_out, go DONE.
REQ-020 DONE: res_valid=1 for exactly this cycle; always go IDLE next cycle; start ignored in DONE (still the completed instruction).
REQ-021 stall SHALL be combinational: (IDLE and start and not flush) or EXEC; stall=0 in DONE.
REQ-022 Accept in cycle T0 -> res_valid high in cycle T0+L+1; stall high cycles T0..T0+L.
REQ-023 Back-to-back ops: minimum one IDLE cycle between DONE and next accept; new op accepted in the cycle after DONE if start high.
REQ-024 op changes while in EXEC SHALL be ignored; op_q and counter unaffected.
REQ-025 start dropping in EXEC SHALL NOT abort; operation completes normally.
REQ-026 flush in any state SHALL force IDLE next cycle, suppress res_valid, leave res_out/flags_out/op_q unchanged; flush has priority over start and counter completion.
REQ-027 res_out/flags_out SHALL change only on EXEC completion capture.
REQ-028 Counter SHALL never wrap; it is loaded only in IDLE accept and stops at 0.

Reset
REQ-029 reset low SHALL asynchronously force IDLE, counter=0, op_q=0, res_out=0, flags_out=0, res_valid=0, busy=0.
REQ-030 stall SHALL be 0 during reset regardless of start.
REQ-031 Reset mid-EXEC SHALL discard the operation; no res_valid after release.
REQ-032 First accept possible on the first rising edge after reset deasserts.

Verification
REQ-033 op=5'b00000, start=1 at T0, res_in=32'h3F800000 -> stall T0..T1, res_valid at T2, res_out=32'h3F800000.
REQ-034 op=5'b00010 (2-cycle), start held -> stall T0..T2, res_valid at T3 only; start held through DONE -> no re-accept in DONE, re-accept at T4.
REQ-035 op=5'b00110, DIV_LAT=24, flags_in=5'b00001 at completion -> busy 24 cycles, res_valid at T25, flags_out=5'b00001.
REQ-036 op=5'b01101 accepted, flush at T5 -> IDLE at T6, no res_valid, res_out unchanged from prior value.
REQ-037 op=5'b00110 accepted, reset low at T10 -> all outputs 0 immediately, stall=0, no res_valid after release.
REQ-038 op changed to 5'b00000 mid-EXEC of a DIV op -> op_q stays 5'b00110, completion still at T0+DIV_LAT+1.
